// File: rtl/stage2_decode_sb.sv
// Decode stage: holds one instruction, reads the register file with stage-5 bypass, and issues
// to execute once a per-register scoreboard shows no outstanding write on any operand or target.
module stage2_decode_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned PCW   = 30,
    parameter int unsigned LR    = 15,
    parameter int unsigned RSEL  = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     ir_i,
    input  logic [PCW-1:0]  nextpc_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [1:0]      control_branch_o,
    output logic            control_load_o,
    output logic            control_store_o,
    output logic [3:0]      aluop_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [XLEN-1:0] branch_test_val_o,
    output logic            do_wb_o,
    output logic [RSEL-1:0] wb_reg_o,
    input  logic            do_wb_i,
    input  logic [RSEL-1:0] wb_reg_i,
    input  logic [XLEN-1:0] wb_val_i
);

    localparam logic [1:0] BrNone   = 2'd0;
    localparam logic [1:0] BrTake   = 2'd1;
    localparam logic [1:0] BrCondZ  = 2'd2;
    localparam logic [1:0] BrCondNz = 2'd3;
    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluLsr   = 4'd5;
    localparam logic [RSEL-1:0] LrSel = RSEL'(LR);

    logic            hold_valid_q, hold_valid_d;
    logic [31:0]     ir_q, ir_d;
    logic [PCW-1:0]  nextpc_q, nextpc_d;
    logic [NREGS-1:0] sb_q, sb_d;
    logic [XLEN-1:0] rf_q [NREGS];

    logic [RSEL-1:0] rd_sel, ra_sel, rb_sel;
    logic [XLEN-1:0] rd_val, ra_val, rb_val;

    assign rd_sel = RSEL'(ir_q[27:24]);
    assign ra_sel = RSEL'(ir_q[19:16]);
    assign rb_sel = RSEL'(ir_q[15:12]);

    // Same-cycle writeback must win over the stale regfile copy on every read port.
    assign rd_val = (do_wb_i && wb_reg_i == rd_sel) ? wb_val_i : rf_q[rd_sel];
    assign ra_val = (do_wb_i && wb_reg_i == ra_sel) ? wb_val_i : rf_q[ra_sel];
    assign rb_val = (do_wb_i && wb_reg_i == rb_sel) ? wb_val_i : rf_q[rb_sel];

    logic [1:0]      dec_branch;
    logic            dec_load, dec_store, dec_wb;
    logic [3:0]      dec_aluop;
    logic [XLEN-1:0] dec_a, dec_b;
    logic [RSEL-1:0] dec_wb_reg;
    logic            use_ra, use_rb, use_rd;

    always_comb begin
        dec_branch = BrNone;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_wb     = 1'b0;
        dec_aluop  = AluAdd;
        dec_a      = '0;
        dec_b      = '0;
        dec_wb_reg = rd_sel;
        use_ra     = 1'b0;
        use_rb     = 1'b0;
        use_rd     = 1'b0;
        unique case (ir_q[31:30])
            2'b00, 2'b01: begin
                dec_aluop = ir_q[23:20];
                dec_a     = ra_val;
                dec_b     = ir_q[30] ? rb_val : {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
                use_ra    = 1'b1;
                use_rb    = ir_q[30];
                case (ir_q[29:28])
                    2'b01: begin
                        dec_load = 1'b1;
                        dec_wb   = 1'b1;
                    end
                    2'b10: begin
                        dec_store = 1'b1;
                        use_rd    = 1'b1;
                    end
                    default: dec_wb = 1'b1;
                endcase
            end
            2'b10: begin
                if (!ir_q[29]) begin
                    dec_a     = XLEN'(nextpc_q);
                    dec_b     = {{(XLEN-22){ir_q[21]}}, ir_q[21:0]};
                    dec_aluop = AluAdd;
                end else begin
                    dec_a     = ra_val;
                    dec_b     = XLEN'(2);
                    dec_aluop = AluLsr;
                    use_ra    = 1'b1;
                end
                dec_branch = ir_q[28] ? (ir_q[22] ? BrCondZ : BrCondNz) : BrTake;
                use_rd     = ir_q[28];
                if (ir_q[23]) begin
                    dec_wb     = 1'b1;
                    dec_wb_reg = LrSel;
                end
            end
            default: ;
        endcase
    end

    // A scoreboard bit cleared by this cycle's writeback no longer blocks.
    logic ra_busy, rb_busy, rd_busy, dst_busy, hazard, issue;
    assign ra_busy  = sb_q[ra_sel] && !(do_wb_i && wb_reg_i == ra_sel);
    assign rb_busy  = sb_q[rb_sel] && !(do_wb_i && wb_reg_i == rb_sel);
    assign rd_busy  = sb_q[rd_sel] && !(do_wb_i && wb_reg_i == rd_sel);
    assign dst_busy = sb_q[dec_wb_reg] && !(do_wb_i && wb_reg_i == dec_wb_reg);
    assign hazard   = (use_ra && ra_busy) || (use_rb && rb_busy) || (use_rd && rd_busy) ||
                      (dec_wb && dst_busy);

    assign valid_o = hold_valid_q && !hazard;
    assign issue   = valid_o && ready_i;
    assign ready_o = !hold_valid_q || issue || flush_i;

    assign control_branch_o  = hold_valid_q ? dec_branch : BrNone;
    assign control_load_o    = hold_valid_q && dec_load;
    assign control_store_o   = hold_valid_q && dec_store;
    assign do_wb_o           = hold_valid_q && dec_wb;
    assign wb_reg_o          = dec_wb_reg;
    assign aluop_o           = dec_aluop;
    assign alu_a_o           = dec_a;
    assign alu_b_o           = dec_b;
    assign branch_test_val_o = rd_val;

    always_comb begin
        hold_valid_d = hold_valid_q;
        ir_d         = ir_q;
        nextpc_d     = nextpc_q;
        if (valid_i && ready_o) begin
            ir_d         = ir_i;
            nextpc_d     = nextpc_i;
            hold_valid_d = 1'b1;
        end else if (issue || flush_i) begin
            hold_valid_d = 1'b0;
        end
        // Set is applied after clear so an issue targeting the written-back register wins.
        sb_d = sb_q;
        if (do_wb_i) sb_d[wb_reg_i] = 1'b0;
        if (issue && do_wb_o) sb_d[wb_reg_o] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_valid_q <= 1'b0;
            ir_q         <= '0;
            nextpc_q     <= '0;
            sb_q         <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            ir_q         <= ir_d;
            nextpc_q     <= nextpc_d;
            sb_q         <= sb_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wb_i) rf_q[wb_reg_i] <= wb_val_i;
    end

endmodule

// File: tb/tb_stage2_decode_sb.sv
// Bench for stage2_decode_sb: accepted instructions are queued by the driver; a monitor decodes
// them against an instruction-level register/pending-set model and checks every issue.
module tb_stage2_decode_sb;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [31:0] ir_i;
    logic [29:0] nextpc_i;
    logic [1:0]  control_branch_o;
    logic        control_load_o, control_store_o, do_wb_o, do_wb_i;
    logic [3:0]  aluop_o, wb_reg_o, wb_reg_i;
    logic [31:0] alu_a_o, alu_b_o, branch_test_val_o, wb_val_i;

    stage2_decode_sb dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o), .ir_i(ir_i),
        .nextpc_i(nextpc_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .control_branch_o(control_branch_o), .control_load_o(control_load_o),
        .control_store_o(control_store_o), .aluop_o(aluop_o), .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o), .branch_test_val_o(branch_test_val_o), .do_wb_o(do_wb_o),
        .wb_reg_o(wb_reg_o), .do_wb_i(do_wb_i), .wb_reg_i(wb_reg_i), .wb_val_i(wb_val_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] ir; logic [29:0] pc; } instr_t;
    typedef struct {
        bit [1:0] br; bit ld; bit st; bit [3:0] op;
        bit [31:0] a; bit [31:0] b; bit [31:0] tv;
        bit wb; bit [3:0] wr; bit [15:0] mask;
    } exp_t;

    instr_t      q[$];
    logic [31:0] mregs [16];
    bit [15:0]   mpend;
    int          n_tests = 0, n_fail = 0, n_issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] rdreg(bit [3:0] r, bit dowb, bit [3:0] wr, bit [31:0] wv);
        return (dowb && wr == r) ? wv : mregs[r];
    endfunction

    // ISA: branch codes none/take/cond_z/cond_nz = 0..3; ADD = 0, LSR = 5.
    function automatic exp_t decode(instr_t i, bit dowb, bit [3:0] wr, bit [31:0] wv);
        exp_t e;
        int   imm;
        bit [3:0] rd = i.ir[27:24], ra = i.ir[19:16], rb = i.ir[15:12];
        e = '{default: '0};
        e.tv = rdreg(rd, dowb, wr, wv);
        if (i.ir[31:30] != 2'b11) e.wr = rd;
        if (i.ir[31] == 1'b0) begin
            e.op = i.ir[23:20];
            e.a = rdreg(ra, dowb, wr, wv);
            imm = $signed(i.ir[15:0]);
            e.b = i.ir[30] ? rdreg(rb, dowb, wr, wv) : imm;
            e.mask = 16'h1 << ra;
            if (i.ir[30]) e.mask |= 16'h1 << rb;
            if (i.ir[29:28] == 2'b01) begin e.ld = 1; e.wb = 1; end
            else if (i.ir[29:28] == 2'b10) begin e.st = 1; e.mask |= 16'h1 << rd; end
            else e.wb = 1;
        end else if (i.ir[30] == 1'b0) begin
            if (!i.ir[29]) begin
                e.a = {2'b00, i.pc};
                imm = $signed(i.ir[21:0]);
                e.b = imm;
                e.op = 4'd0;
            end else begin
                e.a = rdreg(ra, dowb, wr, wv);
                e.b = 2;
                e.op = 4'd5;
                e.mask = 16'h1 << ra;
            end
            e.br = i.ir[28] ? (i.ir[22] ? 2'd2 : 2'd3) : 2'd1;
            if (i.ir[28]) e.mask |= 16'h1 << rd;
            if (i.ir[23]) begin e.wb = 1; e.wr = 4'd15; end
        end
        if (e.wb) e.mask |= 16'h1 << e.wr;
        return e;
    endfunction

    // Monitor: runs on the falling edge when all inputs and outputs are settled.
    initial forever begin
        bit held, ev;
        bit [15:0] eff;
        exp_t e;
        @(negedge clk_i);
        if (!rst_n_i) begin
            chk("rst_valid", valid_o, 0);
            chk("rst_ready", ready_o, 1);
            chk("rst_ctl", {control_branch_o, control_load_o, control_store_o, do_wb_o}, 0);
        end else begin
            held = q.size() > 0;
            e = '{default: '0};
            if (held) e = decode(q[0], do_wb_i, wb_reg_i, wb_val_i);
            eff = mpend & ~(do_wb_i ? (16'h1 << wb_reg_i) : 16'h0);
            ev = held && ((e.mask & eff) == 16'h0);
            chk("valid_o", valid_o, ev);
            chk("ready_o", ready_o, !held || (ev && ready_i) || flush_i);
            if (ev) begin
                chk("branch", control_branch_o, e.br);
                chk("load", control_load_o, e.ld);
                chk("store", control_store_o, e.st);
                chk("aluop", aluop_o, e.op);
                chk("alu_a", alu_a_o, e.a);
                chk("alu_b", alu_b_o, e.b);
                chk("test_val", branch_test_val_o, e.tv);
                chk("do_wb", do_wb_o, e.wb);
                if (e.wb) chk("wb_reg", wb_reg_o, e.wr);
            end else if (!held) begin
                chk("idle_ctl", {control_branch_o, control_load_o, control_store_o, do_wb_o}, 0);
            end
            if (do_wb_i) begin
                mregs[wb_reg_i] = wb_val_i;
                mpend[wb_reg_i] = 1'b0;
            end
            if (ev && ready_i) begin
                if (e.wb) mpend[e.wr] = 1'b1;
                void'(q.pop_front());
                n_issued++;
            end else if (flush_i && held) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] ir, input logic [29:0] pc, input bit fl,
                       input bit rdy, input bit wb, input logic [3:0] wr, input logic [31:0] wv);
        instr_t t;
        @(posedge clk_i); #1;
        valid_i = v; ir_i = ir; nextpc_i = pc; flush_i = fl; ready_i = rdy;
        do_wb_i = wb; wb_reg_i = wr; wb_val_i = wv;
        @(negedge clk_i); #1;
        if (rst_n_i && valid_i && ready_o) begin
            t.ir = ir_i; t.pc = nextpc_i;
            q.push_back(t);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_n_i = 1'b0; valid_i = 0; flush_i = 0; ready_i = 0; do_wb_i = 0;
        q.delete();
        mpend = '0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
    endtask

    task automatic rand_cyc();
        bit fl, wb;
        logic [3:0] wr;
        int s;
        fl = ($urandom % 10) == 0;
        wb = 0; wr = 4'($urandom);
        if (mpend != 0 && ($urandom % 2) == 1) begin
            s = $urandom % 16;
            for (int k = 0; k < 16; k++) begin
                if (!wb && mpend[(s + k) % 16]) begin wb = 1; wr = 4'((s + k) % 16); end
            end
        end
        cyc(($urandom % 4) != 0, $urandom, 30'($urandom), fl, fl ? 1'b0 : (($urandom % 4) != 0),
            wb, wr, $urandom);
    endtask

    initial begin
        rst_n_i = 1'b0; valid_i = 0; ir_i = 0; nextpc_i = 0; flush_i = 0; ready_i = 0;
        do_wb_i = 0; wb_reg_i = 0; wb_val_i = 0; mpend = '0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        for (int r = 0; r < 16; r++) cyc(0, 0, 0, 0, 1, 1, 4'(r), $urandom);

        // r1 <- r2 + r3, then r4 <- r1 + 7 stalls until r1 = 0x55 is written back.
        cyc(1, {2'b01, 2'b00, 4'd1, 4'd0, 4'd2, 4'd3, 12'd0}, 30'h4, 0, 1, 0, 0, 0);
        cyc(1, {2'b00, 2'b00, 4'd4, 4'd0, 4'd1, 16'd7}, 30'h5, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 4'd1, 32'h55);
        // Held store stalled by ready_i low for three cycles.
        cyc(1, {2'b01, 2'b10, 4'd2, 4'd3, 4'd3, 4'd2, 12'd0}, 30'h6, 0, 1, 0, 0, 0);
        repeat (3) cyc(1, {2'b00, 2'b00, 4'd9, 4'd1, 4'd2, 16'hFFFF}, 30'h7, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // Branch-and-link, imm22 = -4, nextpc = 0x10.
        cyc(1, {2'b10, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 22'h3FFFFC}, 30'h10, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // Flush a held r5 writer while loading an r5 reader.
        cyc(1, {2'b00, 2'b00, 4'd5, 4'd0, 4'd2, 16'd1}, 30'h20, 0, 0, 0, 0, 0);
        cyc(1, {2'b00, 2'b00, 4'd6, 4'd0, 4'd5, 16'd2}, 30'h21, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // r7 writer issues while r7 is written back: bit stays set, r7 reader stalls.
        cyc(1, {2'b00, 2'b00, 4'd7, 4'd0, 4'd0, 16'd3}, 30'h30, 0, 1, 0, 0, 0);
        cyc(1, {2'b00, 2'b00, 4'd8, 4'd0, 4'd7, 16'd4}, 30'h31, 0, 1, 1, 4'd7, 32'h77);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 4'd7, 32'h78);

        for (int n = 0; n < 400; n++) rand_cyc();
        // Reset with an instruction held and scoreboard bits outstanding.
        cyc(1, {2'b00, 2'b00, 4'd9, 4'd0, 4'd1, 16'd1}, 30'h40, 0, 1, 0, 0, 0);
        cyc(1, {2'b00, 2'b00, 4'd10, 4'd0, 4'd9, 16'd1}, 30'h41, 0, 0, 0, 0, 0);
        do_reset();
        cyc(1, {2'b00, 2'b00, 4'd11, 4'd0, 4'd9, 16'd1}, 30'h42, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 400; n++) rand_cyc();

        chk("issued_enough", n_issued > 100, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
